// File: rtl/ifu_fetch.sv
// Instruction fetch unit: walks a PC through instruction memory, one request outstanding at a
// time, and hands each fetched word to decode through a valid/ready handshake. Control-flow
// redirects from execute retarget the PC and squash any in-flight response.
// Optional performance counters are enabled by defining IFU_FETCH_PERF_EN.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef IFU_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StHold
  } state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic        r_kill;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_mem_en;
  logic        r_inst_valid;

  logic        w_mem_fire;
  logic        w_inst_fire;
  logic [31:0] w_pc_inc;

  assign w_mem_fire  = r_mem_en & mem_ready;
  assign w_inst_fire = r_inst_valid & inst_ready;
  // Natural 32-bit wrap: FFFF_FFFC + 4 -> 0.
  assign w_pc_inc    = r_pc + 32'd4;

  // Fetch FSM; mem_en and inst_valid are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_pc         <= RESET_PC;
      r_kill       <= 1'b0;
      r_inst       <= 32'd0;
      r_inst_pc    <= RESET_PC;
      r_mem_en     <= 1'b0;
      r_inst_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (redirect_valid) begin
            r_pc <= redirect_pc;
          end
          r_state  <= StReq;
          r_mem_en <= 1'b1;
        end

        StReq: begin
          // Address may change only through a redirect; otherwise held until accepted.
          if (redirect_valid) begin
            r_pc <= redirect_pc;
          end
          if (w_mem_fire) begin
            r_state  <= StWait;
            r_mem_en <= 1'b0;
            // A request accepted in the redirect cycle fetched the old PC: squash its reply.
            r_kill   <= redirect_valid;
          end
        end

        StWait: begin
          if (redirect_valid) begin
            r_pc <= redirect_pc;
            if (mem_rvalid) begin
              r_kill   <= 1'b0;
              r_state  <= StReq;
              r_mem_en <= 1'b1;
            end else begin
              r_kill <= 1'b1;
            end
          end else if (mem_rvalid) begin
            if (r_kill) begin
              r_kill   <= 1'b0;
              r_state  <= StReq;
              r_mem_en <= 1'b1;
            end else begin
              r_inst       <= mem_rdata;
              r_inst_pc    <= r_pc;
              r_state      <= StHold;
              r_inst_valid <= 1'b1;
            end
          end
        end

        StHold: begin
          // Redirect wins over sequential advance even when decode takes the word this cycle.
          if (redirect_valid || inst_ready) begin
            r_pc         <= redirect_valid ? redirect_pc : w_pc_inc;
            r_state      <= StReq;
            r_inst_valid <= 1'b0;
            r_mem_en     <= 1'b1;
          end
        end

        default: begin
          r_state      <= StIdle;
          r_mem_en     <= 1'b0;
          r_inst_valid <= 1'b0;
        end
      endcase
    end
  end

  assign mem_en     = r_mem_en;
  assign mem_addr   = r_pc;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;

`ifdef IFU_FETCH_PERF_EN
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_stall_cnt;

  // Count delivered instructions and cycles spent requesting or waiting on memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetch_cnt <= 32'd0;
      r_perf_stall_cnt <= 32'd0;
    end else begin
      if (w_inst_fire) begin
        r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      end
      if ((r_state == StReq) || (r_state == StWait)) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = r_perf_fetch_cnt;
  assign perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: directed scenarios plus a randomized run, with a transaction-level
// scoreboard that tracks the expected PC, outstanding request and held instruction.
`timescale 1ns/1ps
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC   = 32'h8000_0000;
  localparam logic [31:0] MAGIC      = 32'hA5A5_0000;
  localparam logic [31:0] STALE_DATA = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef IFU_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int total = 0;
  int bad = 0;

  // Scoreboard state (post-edge view of what the fetcher should be doing).
  logic        armed = 1'b0;
  logic [31:0] exp_pc = RESET_PC;
  logic        owed = 1'b0;
  logic        stale = 1'b0;
  logic        orphan = 1'b0;
  logic        hold_exp = 1'b0;
  logic [31:0] owed_pc = 32'd0;
  logic [31:0] hold_pc = 32'd0;
  logic        mf_last = 1'b0;
  int          lat = 1;
  int          age = 0;
  int          mem_lat = 1;
  logic        rand_lat = 1'b0;
  logic        spur_en = 1'b0;
  logic        keep_orphan = 1'b0;
  int          cyc = 0;
  int          fetch_model = 0;
  int          stall_model = 0;
  int          n_fires = 0;
  logic [31:0] deliv_q[$];
  int          fire_q[$];

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_en         (mem_en),
    .mem_addr       (mem_addr),
    .mem_ready      (mem_ready),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef IFU_FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Scoreboard: check this cycle's outputs, then advance the model across the coming edge.
  always @(negedge clk) begin : mon
    logic mf;
    logic ifr;
    cyc++;
    if (rst) begin
      armed       = 1'b1;
      exp_pc      = RESET_PC;
      orphan      = keep_orphan && (owed || orphan);
      owed        = 1'b0;
      stale       = 1'b0;
      hold_exp    = 1'b0;
      mf_last     = 1'b0;
      fetch_model = 0;
      stall_model = 0;
      deliv_q.delete();
      fire_q.delete();
    end else if (armed) begin
      total++;
      if (inst_valid !== hold_exp) begin
        bad++;
        $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, hold_exp);
      end
      if (mem_en === 1'b1) begin
        total++;
        if (mem_addr !== exp_pc) begin
          bad++;
          $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, exp_pc);
        end
        total++;
        if (owed || hold_exp) begin
          bad++;
          $display("FAIL single_outstanding cyc=%0d got mem_en=1 exp mem_en=0", cyc);
        end
      end
      if (hold_exp) begin
        total++;
        if ((inst_pc !== hold_pc) || (inst !== (hold_pc ^ MAGIC))) begin
          bad++;
          $display("FAIL held_inst cyc=%0d got pc=%h inst=%h exp pc=%h inst=%h", cyc, inst_pc,
                   inst, hold_pc, hold_pc ^ MAGIC);
        end
      end
`ifdef IFU_FETCH_PERF_EN
      total++;
      if ((perf_fetch_cnt !== 32'(fetch_model)) || (perf_stall_cnt !== 32'(stall_model))) begin
        bad++;
        $display("FAIL perf_cnt cyc=%0d got fetch=%0d stall=%0d exp fetch=%0d stall=%0d", cyc,
                 perf_fetch_cnt, perf_stall_cnt, fetch_model, stall_model);
      end
`endif
      mf  = mem_en & mem_ready;
      ifr = inst_valid & inst_ready;
      if (mem_en || owed) stall_model++;
      // Response from the memory.
      if (mem_rvalid && owed) begin
        if (!stale && !redirect_valid) begin
          hold_exp = 1'b1;
          hold_pc  = owed_pc;
        end
        owed = 1'b0;
      end else if (mem_rvalid && orphan) begin
        orphan = 1'b0;
      end else if (owed && redirect_valid) begin
        stale = 1'b1;
      end
      // New request accepted.
      if (mf) begin
        owed    = 1'b1;
        owed_pc = exp_pc;
        stale   = redirect_valid;
        lat     = rand_lat ? int'($urandom_range(4, 1)) : mem_lat;
      end
      mf_last = mf;
      // Decode handshake and redirect.
      if (ifr) begin
        fetch_model++;
        n_fires++;
        deliv_q.push_back(inst_pc);
        fire_q.push_back(cyc);
        if (!redirect_valid) exp_pc = exp_pc + 32'd4;
      end
      if (ifr || redirect_valid) hold_exp = 1'b0;
      if (redirect_valid) exp_pc = redirect_pc;
    end
  end

  // Memory responder: answers an accepted request after lat cycles, may emit stray rvalids.
  always @(posedge clk) begin
    #1;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (mf_last) age = 0;
    if (owed || orphan) begin
      if (age + 1 >= lat) begin
        mem_rvalid = 1'b1;
        mem_rdata  = (owed && !stale) ? (owed_pc ^ MAGIC) : STALE_DATA;
      end
      age++;
    end else if (spur_en && ($urandom_range(3, 0) == 0)) begin
      mem_rvalid = 1'b1;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    rand_lat = 1'b0;
    spur_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    inst_ready = 1'b1;
    redirect_valid = 1'b0;
    mem_lat = 1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      total++;
      if ((mem_en !== 1'b0) || (inst_valid !== 1'b0) || (mem_addr !== RESET_PC) ||
          (inst !== 32'd0) || (inst_pc !== RESET_PC)) begin
        bad++;
        $display("FAIL reset_state got en=%b v=%b addr=%h inst=%h pc=%h exp 0 0 %h 0 %h", mem_en,
                 inst_valid, mem_addr, inst, inst_pc, RESET_PC, RESET_PC);
      end
`ifdef IFU_FETCH_PERF_EN
      total++;
      if ((perf_fetch_cnt !== 32'd0) || (perf_stall_cnt !== 32'd0)) begin
        bad++;
        $display("FAIL reset_perf got %0d %0d exp 0 0", perf_fetch_cnt, perf_stall_cnt);
      end
`endif
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ((mem_en !== 1'b1) || (mem_addr !== RESET_PC)) begin
      bad++;
      $display("FAIL idle_to_req got en=%b addr=%h exp en=1 addr=%h", mem_en, mem_addr, RESET_PC);
    end
    mem_ready = 1'b0;
    inst_ready = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    mem_lat = 1;
    mem_ready = 1'b1;
    inst_ready = 1'b1;
    for (int i = 0; i < 40 && fire_q.size() < 3; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if (fire_q.size() < 3) begin
      bad++;
      $display("FAIL stream_timeout got fires=%0d exp 3", fire_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        logic [31:0] e;
        e = RESET_PC + 32'(4 * k);
        total++;
        if (deliv_q[k] !== e) begin
          bad++;
          $display("FAIL stream_pc[%0d] got=%h exp=%h", k, deliv_q[k], e);
        end
      end
      for (int k = 1; k < 3; k++) begin
        total++;
        if (fire_q[k] - fire_q[k-1] != 3) begin
          bad++;
          $display("FAIL stream_rate[%0d] got=%0d exp=3", k, fire_q[k] - fire_q[k-1]);
        end
      end
    end
  endtask

  task automatic test_mem_stall();
    do_reset();
    mem_lat = 4;
    inst_ready = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ((mem_en !== 1'b1) || (mem_addr !== RESET_PC)) begin
        bad++;
        $display("FAIL stall_addr[%0d] got en=%b addr=%h exp en=1 addr=%h", i, mem_en, mem_addr,
                 RESET_PC);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    total++;
    if (mem_en !== 1'b0) begin
      bad++;
      $display("FAIL mem_en_after_accept got=%b exp=0", mem_en);
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if ((fire_q.size() != 1) || (deliv_q[0] !== RESET_PC)) begin
      bad++;
      $display("FAIL stall_single_inst got fires=%0d exp 1 at %h", fire_q.size(), RESET_PC);
    end
  endtask

  task automatic test_decode_stall();
    logic [31:0] v_inst;
    logic [31:0] v_pc;
    do_reset();
    mem_lat = 1;
    mem_ready = 1'b1;
    inst_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (inst_valid === 1'b1) break;
    end
    total++;
    if (inst_valid !== 1'b1) begin
      bad++;
      $display("FAIL hold_timeout got inst_valid=%b exp=1", inst_valid);
    end
    v_inst = inst;
    v_pc = inst_pc;
    total++;
    if ((v_pc !== RESET_PC) || (v_inst !== (RESET_PC ^ MAGIC))) begin
      bad++;
      $display("FAIL hold_value got pc=%h inst=%h exp pc=%h inst=%h", v_pc, v_inst, RESET_PC,
               RESET_PC ^ MAGIC);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++;
      if ((inst !== v_inst) || (inst_pc !== v_pc) || (mem_en !== 1'b0) || (inst_valid !== 1'b1))
      begin
        bad++;
        $display("FAIL hold_stable[%0d] got inst=%h pc=%h en=%b v=%b exp %h %h 0 1", i, inst,
                 inst_pc, mem_en, inst_valid, v_inst, v_pc);
      end
    end
    inst_ready = 1'b1;
    @(posedge clk); #1;
    inst_ready = 1'b0;
    total++;
    if ((mem_en !== 1'b1) || (mem_addr !== RESET_PC + 32'd4)) begin
      bad++;
      $display("FAIL next_fetch got en=%b addr=%h exp en=1 addr=%h", mem_en, mem_addr,
               RESET_PC + 32'd4);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    mem_lat = 3;
    mem_ready = 1'b1;
    inst_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (mem_en !== 1'b0) begin
      bad++;
      $display("FAIL enter_wait got mem_en=%b exp=0", mem_en);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_1000;
    mem_lat = 1;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_en === 1'b1) break;
      @(posedge clk); #1;
    end
    total++;
    if ((mem_en !== 1'b1) || (mem_addr !== 32'h8000_1000)) begin
      bad++;
      $display("FAIL redir_wait_addr got en=%b addr=%h exp en=1 addr=80001000", mem_en, mem_addr);
    end
    for (int i = 0; i < 20 && fire_q.size() < 1; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if (fire_q.size() < 1) begin
      bad++;
      $display("FAIL redir_wait_timeout got fires=0 exp 1");
    end else if (deliv_q[0] !== 32'h8000_1000) begin
      bad++;
      $display("FAIL redir_wait_first got=%h exp=80001000", deliv_q[0]);
    end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    mem_lat = 1;
    mem_ready = 1'b1;
    inst_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (inst_valid === 1'b1) break;
    end
    total++;
    if (inst_valid !== 1'b1) begin
      bad++;
      $display("FAIL redir_hold_timeout got inst_valid=%b exp=1", inst_valid);
    end
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_2000;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    total++;
    if ((inst_valid !== 1'b0) || (mem_en !== 1'b1) || (mem_addr !== 32'h8000_2000)) begin
      bad++;
      $display("FAIL redir_hold_next got v=%b en=%b addr=%h exp 0 1 80002000", inst_valid, mem_en,
               mem_addr);
    end
    total++;
    if ((fire_q.size() != 1) || (deliv_q[0] !== RESET_PC)) begin
      bad++;
      $display("FAIL redir_hold_once got fires=%0d exp 1 at %h", fire_q.size(), RESET_PC);
    end
    for (int i = 0; i < 20 && fire_q.size() < 2; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if (fire_q.size() < 2) begin
      bad++;
      $display("FAIL redir_hold_timeout2 got fires=%0d exp 2", fire_q.size());
    end else if (deliv_q[1] !== 32'h8000_2000) begin
      bad++;
      $display("FAIL redir_hold_second got=%h exp=80002000", deliv_q[1]);
    end
  endtask

  task automatic test_redirect_idle_req();
    do_reset();
    mem_lat = 1;
    mem_ready = 1'b0;
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_4000;
    @(posedge clk); #1;
    total++;
    if ((mem_en !== 1'b1) || (mem_addr !== 32'h8000_4000)) begin
      bad++;
      $display("FAIL redir_idle got en=%b addr=%h exp en=1 addr=80004000", mem_en, mem_addr);
    end
    redirect_pc = 32'h8000_3000;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    total++;
    if ((mem_en !== 1'b1) || (mem_addr !== 32'h8000_3000)) begin
      bad++;
      $display("FAIL redir_req got en=%b addr=%h exp en=1 addr=80003000", mem_en, mem_addr);
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 20 && fire_q.size() < 1; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if (fire_q.size() < 1) begin
      bad++;
      $display("FAIL redir_req_timeout got fires=0 exp 1");
    end else if (deliv_q[0] !== 32'h8000_3000) begin
      bad++;
      $display("FAIL redir_req_first got=%h exp=80003000", deliv_q[0]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    mem_lat = 2;
    mem_ready = 1'b1;
    inst_ready = 1'b1;
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    total++;
    if (mem_en !== 1'b0) begin
      bad++;
      $display("FAIL stale_accept got mem_en=%b exp=0", mem_en);
    end
    for (int i = 0; i < 40 && fire_q.size() < 2; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if (fire_q.size() < 2) begin
      bad++;
      $display("FAIL wrap_timeout got fires=%0d exp 2", fire_q.size());
    end else if ((deliv_q[0] !== 32'hFFFF_FFFC) || (deliv_q[1] !== 32'h0000_0000)) begin
      bad++;
      $display("FAIL wrap_pc got %h %h exp fffffffc 00000000", deliv_q[0], deliv_q[1]);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    mem_lat = 1;
    mem_ready = 1'b1;
    inst_ready = 1'b1;
    for (int i = 0; i < 60 && fire_q.size() < 4; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if (fire_q.size() < 4) begin
      bad++;
      $display("FAIL four_fetch_timeout got fires=%0d exp 4", fire_q.size());
    end
`ifdef IFU_FETCH_PERF_EN
    total++;
    if (perf_fetch_cnt !== 32'd4) begin
      bad++;
      $display("FAIL perf_four got=%0d exp=4", perf_fetch_cnt);
    end
`endif
    mem_lat = 5;
    keep_orphan = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ((mem_en !== 1'b0) || (inst_valid !== 1'b0) || (mem_addr !== RESET_PC) ||
        (inst !== 32'd0) || (inst_pc !== RESET_PC)) begin
      bad++;
      $display("FAIL mid_wait_reset got en=%b v=%b addr=%h inst=%h pc=%h", mem_en, inst_valid,
               mem_addr, inst, inst_pc);
    end
`ifdef IFU_FETCH_PERF_EN
    total++;
    if ((perf_fetch_cnt !== 32'd0) || (perf_stall_cnt !== 32'd0)) begin
      bad++;
      $display("FAIL mid_wait_perf got %0d %0d exp 0 0", perf_fetch_cnt, perf_stall_cnt);
    end
`endif
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if ((fire_q.size() != 0) || (inst_valid !== 1'b0)) begin
      bad++;
      $display("FAIL dropped_response got fires=%0d v=%b exp 0 0", fire_q.size(), inst_valid);
    end
    keep_orphan = 1'b0;
    mem_lat = 1;
    mem_ready = 1'b1;
    for (int i = 0; i < 20 && fire_q.size() < 1; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if (fire_q.size() < 1) begin
      bad++;
      $display("FAIL post_reset_timeout got fires=0 exp 1");
    end else if (deliv_q[0] !== RESET_PC) begin
      bad++;
      $display("FAIL post_reset_pc got=%h exp=%h", deliv_q[0], RESET_PC);
    end
  endtask

  task automatic test_random();
    int start;
    do_reset();
    rand_lat = 1'b1;
    spur_en = 1'b1;
    start = n_fires;
    for (int i = 0; i < 3000; i++) begin
      mem_ready = ($urandom % 3) != 0;
      inst_ready = ($urandom % 3) != 0;
      redirect_valid = ($urandom % 16) == 0;
      redirect_pc = (($urandom % 4) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      rst = ($urandom % 200) == 0;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
    spur_en = 1'b0;
    rand_lat = 1'b0;
    total++;
    if (n_fires - start < 100) begin
      bad++;
      $display("FAIL random_progress got=%0d exp>=100", n_fires - start);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_mem_stall();
    test_decode_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_redirect_idle_req();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h8000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mem_en  output  1  fetch request valid to instruction memory.
REQ-005 mem_addr  output  32  fetch address; equals current PC while mem_en=1.
REQ-006 mem_ready  input  1  memory accepts request this cycle (fire = mem_en & mem_ready).
REQ-007 mem_rvalid  input  1  response data valid this cycle.
REQ-008 mem_rdata  input  32  fetched instruction word.
REQ-009 inst_valid  output  1  instruction available to decode.
REQ-010 inst_ready  input  1  decode accepts instruction (fire = inst_valid & inst_ready).
REQ-011 inst  output  32  registered instruction word.
REQ-012 inst_pc  output  32  PC of inst.
REQ-013 redirect_valid  input  1  control-flow redirect from execute.
REQ-014 redirect_pc  input  32  redirect target.

Function
REQ-015 States: IDLE, REQ, WAIT, HOLD; mem_en=1 only in REQ; inst_valid=1 only in HOLD.
REQ-016 IDLE -> REQ unconditionally next cycle.
REQ-017 REQ: mem_fire -> WAIT; else stay REQ, mem_addr held stable.
REQ-018 WAIT: mem_rvalid -> inst<=mem_rdata, inst_pc<=pc, -> HOLD; else stay WAIT.
REQ-019 HOLD: inst/inst_pc held stable until inst fire; on fire pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), -> REQ.
REQ-020 Minimum latency: mem_ready and mem_rvalid both 1 every cycle -> one instruction per 3 cycles (REQ, WAIT, HOLD with inst_ready=1).
REQ-021 mem_rvalid outside WAIT (and not killed) is ignored.
REQ-022 Redirect, state REQ, no mem_ready: pc<=redirect_pc, stay REQ; next request uses new PC.
REQ-023 Redirect, state REQ with mem_ready: accepted request is stale; pc<=redirect_pc, kill<=1, -> WAIT.
REQ-024 Redirect, state WAIT: pc<=redirect_pc; if mem_rvalid same cycle, response discarded, -> REQ; else kill<=1, stay WAIT.
REQ-025 WAIT with kill=1 and mem_rvalid: response discarded, kill<=0, -> REQ; inst unchanged.
REQ-026 Redirect, state HOLD: inst_valid drops next cycle, pc<=redirect_pc, -> REQ; if inst fire same cycle, instruction counts as delivered and pc takes redirect_pc, not pc+4.
REQ-027 Redirect in IDLE: pc<=redirect_pc; IDLE -> REQ as normal.
REQ-028 Redirect has priority over pc+4 update in all states.
REQ-029 Redirect never creates more than one outstanding memory request.

Reset
REQ-030 rst=1 at a clock edge: state<=IDLE, pc<=RESET_PC, kill<=0, inst<=0, inst_pc<=RESET_PC, regardless of current state or handshakes.
REQ-031 Outputs in cycle after reset edge: mem_en=0, inst_valid=0, mem_addr=RESET_PC, inst=0, inst_pc=RESET_PC.
REQ-032 Reset mid-transaction (WAIT): in-flight response discarded; no instruction delivered for it.

Configuration
REQ-033 Macro IFU_FETCH_PERF_EN defined: adds outputs perf_fetch_cnt (32) and perf_stall_cnt (32).
REQ-034 perf_fetch_cnt +1 per inst fire; perf_stall_cnt +1 per cycle in REQ or WAIT; both reset to 0, wrap at 2^32.
REQ-035 Macro undefined: ports and counters absent; all other behaviour identical.

Verification
REQ-036 Reset, mem_ready=mem_rvalid=inst_ready=1 constant, mem_rdata=pc-derived -> inst_pc sequence 80000000, 80000004, 80000008, one inst fire per 3 cycles.
REQ-037 mem_ready low 5 cycles, then mem_rvalid delayed 4 cycles -> mem_addr stable at 80000000 throughout, single inst delivered, mem_en deasserts after accept.
REQ-038 inst_ready low 10 cycles in HOLD -> inst and inst_pc stable, mem_en=0, no pc change; on ready, next fetch at +4.
REQ-039 Redirect to 80001000 in WAIT, mem_rvalid 2 cycles later with 0xDEADBEEF -> data discarded, next mem_addr=80001000, first delivered inst_pc=80001000.
REQ-040 Redirect to 80002000 coincident with inst fire in HOLD -> that inst delivered once, next mem_addr=80002000.
REQ-041 With IFU_FETCH_PERF_EN: 4 fetches, 1-cycle mem latency, rst pulsed mid-WAIT -> counters return to 0, pc=80000000, dropped response not counted.
